reg_readout_serializer: RTL and testbench

//  Read side of the register bank: on a request, fetches one word from the bank's

---
 rtl/reg_readout_serializer_if.sv | 28 ++
 rtl/reg_readout_serializer.sv | 105 ++++++++++
 tb/tb_reg_readout_serializer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_readout_serializer_if.sv
// Bundle for the register read serializer: request handshake, bank read
// port and serial output link. The master side is whatever issues requests
// and hosts the register bank; the slave side is the serializer itself.
interface reg_readout_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ser_data;
    logic                  ser_valid;
    logic                  ser_last;
    logic                  busy;

    modport master (
        output req_valid, req_addr, rd_data,
        input  req_ready, rd_en, rd_addr, ser_data, ser_valid, ser_last, busy
    );

    modport slave (
        input  req_valid, req_addr, rd_data,
        output req_ready, rd_en, rd_addr, ser_data, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/reg_readout_serializer.sv
// reg_readout_serializer: on an accepted request, reads one word from the
// register bank's synchronous read port and shifts it out MSB first with
// valid/last strobes. One word per request, no back-pressure on the link.
// Optional feature macro: PARITY_EN appends an even-parity bit (XOR of the
// captured word) after the data bits and moves ser_last onto it.
module reg_readout_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic clock,
    input  logic reset,
    reg_readout_serializer_if.slave bus
);
`ifdef PARITY_EN
    localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int FRAME_BITS = DATA_WIDTH;
`endif
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [FRAME_BITS-1:0]   load_word;
    logic                    shifting;

    // Word as it enters the shift register; parity rides in the LSB slot.
`ifdef PARITY_EN
    assign load_word = {bus.rd_data, ^bus.rd_data};
`else
    assign load_word = bus.rd_data;
`endif

    // State and datapath registers; reset aborts any frame immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and datapath updates for the IDLE->FETCH->WAIT->SHIFT walk.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_next  = bus.req_addr;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Bank data is valid this cycle; capture it once so later
                // changes on rd_data cannot disturb the frame.
                shift_next = load_word;
                cnt_next   = '0;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
                if (cnt_reg == LAST_CNT) begin
                    // Hold the counter at its final value rather than wrap.
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure state decodes so they follow reset without delay.
    assign shifting      = (state_reg == ST_SHIFT);
    assign bus.req_ready = (state_reg == ST_IDLE);
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.rd_en     = (state_reg == ST_FETCH);
    assign bus.rd_addr   = addr_reg;
    assign bus.ser_valid = shifting;
    assign bus.ser_data  = shifting & shift_reg[FRAME_BITS-1];
    assign bus.ser_last  = shifting && (cnt_reg == LAST_CNT);
endmodule

// File: tb/tb_reg_readout_serializer.sv
// Bench for reg_readout_serializer: hosts a small register bank model,
// issues directed and random requests, and checks each frame against the
// bit sequence derived from the addressed word. Honours PARITY_EN.
module tb_reg_readout_serializer;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    reg_readout_serializer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    reg_readout_serializer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] bank [16];
    logic [DW-1:0] rd_data_q = '0;
    bit            scramble  = 1'b0;
    int            n_checks  = 0;
    int            n_fail    = 0;

    // Synchronous-read bank; with scramble set, rd_data is zeroed on every
    // non-read cycle so a late change after capture becomes visible.
    always @(posedge clock) begin
        if (bus.rd_en)
            rd_data_q <= bank[bus.rd_addr];
        else if (scramble)
            rd_data_q <= '0;
    end
    assign bus.rd_data = rd_data_q;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request in an IDLE cycle; it is accepted on the next edge.
    task automatic issue(input logic [AW-1:0] a);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        chk(bus.req_ready, 1, "req_ready_idle");
        chk(bus.busy, 0, "busy_idle");
        chk(bus.ser_valid, 0, "ser_valid_idle");
        $display("request addr=%0h word=%02h", a, bank[a]);
    endtask

    // Follow one frame from the FETCH cycle onward. keep_valid/next_addr set
    // the request lines after the accept edge; inject raises a request with
    // addr 7 mid-frame; abort_at >= 0 pulls reset low on that bit.
    task automatic frame(input logic [AW-1:0] a, input bit keep_valid,
                         input logic [AW-1:0] next_addr, input bit inject,
                         input int abort_at);
        logic [DW-1:0] word;
        bit            exp_q [$];
        int            nbits;
        word = bank[a];
        for (int b = DW - 1; b >= 0; b--) exp_q.push_back(word[b]);
`ifdef PARITY_EN
        exp_q.push_back(^word);
`endif
        nbits = exp_q.size();

        @(negedge clock);
        bus.req_valid = keep_valid;
        bus.req_addr  = next_addr;
        chk(bus.rd_en, 1, "rd_en_fetch");
        chk(bus.rd_addr, a, "rd_addr");
        chk(bus.busy, 1, "busy_fetch");
        chk(bus.req_ready, 0, "req_ready_fetch");
        chk(bus.ser_valid, 0, "ser_valid_fetch");

        @(negedge clock);
        chk(bus.rd_en, 0, "rd_en_one_cycle");
        chk(bus.ser_valid, 0, "ser_valid_wait");
        chk(bus.ser_data, 0, "ser_data_gated");

        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            if (inject && i == 2) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 4'h7;
            end
            if (inject && i == nbits - 1) bus.req_valid = 1'b0;
            chk(bus.ser_valid, 1, "ser_valid_bit");
            chk(bus.ser_data, exp_q[i], "ser_data_bit");
            chk(bus.ser_last, (i == nbits - 1) ? 1 : 0, "ser_last_bit");
            chk(bus.rd_en, 0, "rd_en_shift");
            chk(bus.req_ready, 0, "req_ready_shift");
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk(bus.ser_valid, 0, "abort_ser_valid");
                chk(bus.ser_last, 0, "abort_ser_last");
                chk(bus.busy, 0, "abort_busy");
                chk(bus.req_ready, 1, "abort_req_ready");
                @(negedge clock);
                reset = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    chk(bus.ser_valid, 0, "after_abort_ser_valid");
                    chk(bus.rd_en, 0, "after_abort_rd_en");
                end
                $display("frame addr=%0h aborted at bit %0d", a, i);
                return;
            end
        end

        @(negedge clock);
        chk(bus.ser_valid, 0, "ser_valid_end");
        chk(bus.ser_last, 0, "ser_last_end");
        chk(bus.busy, 0, "busy_end");
        chk(bus.req_ready, 1, "req_ready_end");
        $display("frame addr=%0h word=%02h bits=%0d done", a, word, nbits);
    endtask

    initial begin
        logic [AW-1:0] ra;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        for (int i = 0; i < 16; i++) bank[i] = DW'($urandom);
        bank[3] = 8'hA5;
        bank[4] = 8'h3C;
        bank[5] = 8'h07;
        bank[9] = 8'hFF;

        // Reset state.
        repeat (2) @(negedge clock);
        chk(bus.req_ready, 1, "reset_req_ready");
        chk(bus.rd_en, 0, "reset_rd_en");
        chk(bus.rd_addr, 0, "reset_rd_addr");
        chk(bus.ser_valid, 0, "reset_ser_valid");
        chk(bus.ser_data, 0, "reset_ser_data");
        chk(bus.ser_last, 0, "reset_ser_last");
        chk(bus.busy, 0, "reset_busy");
        reset = 1'b1;

        // Basic frame of 8'hA5.
        issue(4'd3);
        frame(4'd3, 1'b0, 4'd0, 1'b0, -1);

        // Back-to-back with req_valid held: addr 3 then 4.
        issue(4'd3);
        frame(4'd3, 1'b1, 4'd4, 1'b0, -1);
        frame(4'd4, 1'b0, 4'd0, 1'b0, -1);

        // Request with addr 7 during SHIFT is ignored.
        issue(4'd3);
        frame(4'd3, 1'b0, 4'd0, 1'b1, -1);

        // Reset on the 4th bit of an 8'hFF frame.
        issue(4'd9);
        frame(4'd9, 1'b0, 4'd0, 1'b0, 3);

        // rd_data zeroed after capture.
        scramble = 1'b1;
        issue(4'd3);
        frame(4'd3, 1'b0, 4'd0, 1'b0, -1);
        scramble = 1'b0;

        // Word with odd population (parity 1 when enabled).
        issue(4'd5);
        frame(4'd5, 1'b0, 4'd0, 1'b0, -1);

        // Random addresses and contents with random idle gaps.
        for (int n = 0; n < 8; n++) begin
            ra = AW'($urandom_range(15));
            @(negedge clock);
            bank[ra] = DW'($urandom);
            issue(ra);
            frame(ra, 1'b0, 4'd0, 1'b0, -1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
